id_ex_stage: RTL and testbench

- Sits directly downstream of the decode-stage forwarding unit.
- Applies its forwardingA/forwardingB selects to the register-file read data.
- Registers the resolved operands, immediate, register indices and control bits into the EX stage.
- Owns load-use hazard detection: a 2-state FSM stalls decode and injects bubbles into EX until a load result can be forwarded from WB.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/load_use_fsm.sv | 54 +++++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: default widths,
// operand forwarding select encodings and the load-use FSM state type.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    // Operand source selects driven by the decode-stage forwarding unit.
    // Encoding 3 is reserved and falls back to the register file value.
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_W   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;

    // RUN: normal issue. LU_M: the producing load sits in MEM, where
    // aluOutM still holds its address rather than the loaded data.
    typedef enum logic {
        RUN  = 1'b0,
        LU_M = 1'b1
    } lu_state_t;

endpackage

// File: rtl/load_use_fsm.sv
// Load-use hazard detector. A load in EX whose destination feeds the
// instruction in decode holds decode for two cycles, so the consumer
// enters EX only once the load result is available on resultW.
module load_use_fsm
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validD,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              usesRtD,
    input  logic              validE,
    input  logic              memReadE,
    input  logic [REG_AW-1:0] rtE,
    output logic              stallD
);

    lu_state_t state;
    logic      hzd;

    // Hazard when a valid load in EX writes a nonzero register that the
    // valid decode instruction reads; rt only counts when it is a source.
    always_comb begin
        hzd = validD & validE & memReadE & (rtE != '0) &
              ((rtE == rsD) | (usesRtD & (rtE == rtD)));
    end

    // Stall request: detected hazard in RUN, any valid decode slot in
    // LU_M; never while reset is asserted.
    always_comb begin
        stallD = 1'b0;
        if (rst_n) begin
            stallD = (state == RUN) ? hzd : validD;
        end
    end

    // State register: one extra cycle in LU_M after each detected hazard.
    // A flush does not affect the sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (hzd) state <= LU_M;
                LU_M:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: resolves forwarded operands in decode,
// registers the instruction into EX and inserts bubbles on flush or on
// a load-use stall.
// Optional build macro STALL_CNT_EN adds a 32-bit wrapping counter of
// stalled decode cycles on output stallCntE.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validD,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rdD,
    input  logic              usesRtD,
    input  logic              memReadD,
    input  logic [DATA_W-1:0] rd1D,
    input  logic [DATA_W-1:0] rd2D,
    input  logic [DATA_W-1:0] immD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [1:0]        forwardingA,
    input  logic [1:0]        forwardingB,
    input  logic [DATA_W-1:0] aluOutM,
    input  logic [DATA_W-1:0] resultW,
    input  logic              flushE,
    output logic              stallD,
    output logic              validE,
    output logic [DATA_W-1:0] srcAE,
    output logic [DATA_W-1:0] srcBE,
    output logic [DATA_W-1:0] immE,
    output logic [REG_AW-1:0] rsE,
    output logic [REG_AW-1:0] rtE,
    output logic [REG_AW-1:0] rdE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic              memReadE
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]       stallCntE
`endif
);

    import pipe_pkg::*;

    logic [DATA_W-1:0] fwdA;
    logic [DATA_W-1:0] fwdB;

    // Reserved select 3 behaves like the register file path.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] w_val,
        input logic [DATA_W-1:0] m_val
    );
        case (sel)
            FWD_W:   return w_val;
            FWD_M:   return m_val;
            default: return reg_val;
        endcase
    endfunction

    // Decode-side operand resolution from the forwarding selects.
    always_comb begin
        fwdA = fwd_sel(forwardingA, rd1D, resultW, aluOutM);
        fwdB = fwd_sel(forwardingB, rd2D, resultW, aluOutM);
    end

    load_use_fsm #(
        .REG_AW (REG_AW)
    ) u_load_use_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .validD   (validD),
        .rsD      (rsD),
        .rtD      (rtD),
        .usesRtD  (usesRtD),
        .validE   (validE),
        .memReadE (memReadE),
        .rtE      (rtE),
        .stallD   (stallD)
    );

    // EX capture: reset, then bubble on flush/stall, else load decode.
    // Bubble data fields are zeroed so EX never sees stale operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validE   <= 1'b0;
            memReadE <= 1'b0;
            ctrlE    <= '0;
            rsE      <= '0;
            rtE      <= '0;
            rdE      <= '0;
            srcAE    <= '0;
            srcBE    <= '0;
            immE     <= '0;
        end else if (flushE || stallD) begin
            validE   <= 1'b0;
            memReadE <= 1'b0;
            ctrlE    <= '0;
            rsE      <= '0;
            rtE      <= '0;
            rdE      <= '0;
            srcAE    <= '0;
            srcBE    <= '0;
            immE     <= '0;
        end else begin
            validE   <= validD;
            memReadE <= memReadD & validD;
            ctrlE    <= ctrlD;
            rsE      <= rsD;
            rtE      <= rtD;
            rdE      <= rdD;
            srcAE    <= fwdA;
            srcBE    <= fwdB;
            immE     <= immD;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Counts every cycle decode is held; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stallD) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stallCntE = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an expected-result queue: each step
// pushes the EX contents it should produce and pops/compares after the edge.
// Build with STALL_CNT_EN defined to also check the stall counter.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validD;
    logic [4:0]  rsD, rtD, rdD;
    logic        usesRtD, memReadD;
    logic [31:0] rd1D, rd2D, immD;
    logic [7:0]  ctrlD;
    logic [1:0]  forwardingA, forwardingB;
    logic [31:0] aluOutM, resultW;
    logic        flushE;
    logic        stallD, validE, memReadE;
    logic [31:0] srcAE, srcBE, immE;
    logic [4:0]  rsE, rtE, rdE;
    logic [7:0]  ctrlE;
`ifdef STALL_CNT_EN
    logic [31:0] stallCntE;
    logic [31:0] exp_cnt = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        mr;
    } exp_t;

    exp_t sb[$];
    localparam exp_t BUBBLE = '0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .validD      (validD),
        .rsD         (rsD),
        .rtD         (rtD),
        .rdD         (rdD),
        .usesRtD     (usesRtD),
        .memReadD    (memReadD),
        .rd1D        (rd1D),
        .rd2D        (rd2D),
        .immD        (immD),
        .ctrlD       (ctrlD),
        .forwardingA (forwardingA),
        .forwardingB (forwardingB),
        .aluOutM     (aluOutM),
        .resultW     (resultW),
        .flushE      (flushE),
        .stallD      (stallD),
        .validE      (validE),
        .srcAE       (srcAE),
        .srcBE       (srcBE),
        .immE        (immE),
        .rsE         (rsE),
        .rtE         (rtE),
        .rdE         (rdE),
        .ctrlE       (ctrlE),
        .memReadE    (memReadE)
`ifdef STALL_CNT_EN
        ,
        .stallCntE   (stallCntE)
`endif
    );

    // Expected EX contents when the current decode instruction is captured
    // with the given resolved operands.
    function automatic exp_t ld(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.valid = validD;
        e.a     = a;
        e.b     = b;
        e.imm   = immD;
        e.rs    = rsD;
        e.rt    = rtD;
        e.rd    = rdD;
        e.ctrl  = ctrlD;
        e.mr    = memReadD & validD;
        return e;
    endfunction

    task automatic setd(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic ur, input logic mr,
                        input logic [1:0] fa, input logic [1:0] fb);
        validD      = v;
        rsD         = rs;
        rtD         = rt;
        rdD         = rd;
        usesRtD     = ur;
        memReadD    = mr;
        forwardingA = fa;
        forwardingB = fb;
        immD        = immD + 32'h101;
        ctrlD       = ctrlD + 8'h13;
    endtask

    task automatic step(input logic exp_stall, input exp_t e, input string tag);
        exp_t got;
        exp_t want;
        #1;
        total++;
        assert (stallD === exp_stall) else begin
            bad++;
            $error("FAIL %s_stall observed=%0b expected=%0b", tag, stallD, exp_stall);
        end
        sb.push_back(e);
`ifdef STALL_CNT_EN
        if (!rst_n) exp_cnt = 32'd0;
        else if (exp_stall) exp_cnt = exp_cnt + 32'd1;
`endif
        @(posedge clk);
        #1;
        got  = {validE, srcAE, srcBE, immE, rsE, rtE, rdE, ctrlE, memReadE};
        want = sb.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s_ex observed=%h expected=%h", tag, got, want);
        end
`ifdef STALL_CNT_EN
        total++;
        assert (stallCntE === exp_cnt) else begin
            bad++;
            $error("FAIL %s_cnt observed=%h expected=%h", tag, stallCntE, exp_cnt);
        end
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        flushE  = 1'b0;
        rd1D    = 32'h11;
        rd2D    = 32'h44;
        aluOutM = 32'h22;
        resultW = 32'h33;
        immD    = 32'h55;
        ctrlD   = 8'hA5;
        setd(1, 5'd1, 5'd2, 5'd3, 1, 0, 2'd0, 2'd0);

        // Reset held two cycles with a valid decode slot
        step(0, BUBBLE, "reset0");
        step(0, BUBBLE, "reset1");

        // First instruction after release, then forwarding selects on A and B
        rst_n = 1'b1;
        step(0, ld(32'h11, 32'h44), "first");
        setd(1, 5'd1, 5'd2, 5'd3, 1, 0, 2'd2, 2'd0);
        step(0, ld(32'h22, 32'h44), "fwdA_M");
        setd(1, 5'd4, 5'd2, 5'd3, 1, 0, 2'd1, 2'd0);
        step(0, ld(32'h33, 32'h44), "fwdA_W");
        setd(1, 5'd4, 5'd2, 5'd6, 1, 0, 2'd3, 2'd0);
        step(0, ld(32'h11, 32'h44), "fwdA_rsv");
        setd(1, 5'd4, 5'd2, 5'd6, 1, 0, 2'd0, 2'd2);
        step(0, ld(32'h11, 32'h22), "fwdB_M");
        setd(1, 5'd4, 5'd2, 5'd6, 1, 0, 2'd0, 2'd1);
        step(0, ld(32'h11, 32'h33), "fwdB_W");
        setd(1, 5'd4, 5'd2, 5'd6, 1, 0, 2'd0, 2'd3);
        step(0, ld(32'h11, 32'h44), "fwdB_rsv");

        // Load-use on rs: two bubbles, then consumer takes resultW
        setd(1, 5'd1, 5'd5, 5'd0, 0, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "lw5");
        setd(1, 5'd5, 5'd6, 5'd7, 1, 0, 2'd0, 2'd0);
        step(1, BUBBLE, "lu_b1");
        step(1, BUBBLE, "lu_b2");
        forwardingA = 2'd1;
        step(0, ld(32'h33, 32'h44), "lu_cons");

        // Load to $0 is never a hazard
        setd(1, 5'd1, 5'd0, 5'd0, 0, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "lw0");
        setd(1, 5'd0, 5'd0, 5'd9, 1, 0, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "nohz_r0");

        // rt matches but is not a source
        setd(1, 5'd1, 5'd7, 5'd0, 0, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "lw7");
        setd(1, 5'd1, 5'd7, 5'd9, 0, 0, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "nohz_rt");

        // Invalid decode slot never stalls; fields still captured
        setd(1, 5'd1, 5'd8, 5'd0, 0, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "lw8");
        setd(0, 5'd8, 5'd8, 5'd9, 1, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "nohz_inv");

        // Flush in RUN gives a bubble without a stall
        setd(1, 5'd2, 5'd3, 5'd4, 1, 0, 2'd0, 2'd0);
        flushE = 1'b1;
        step(0, BUBBLE, "flush_run");
        flushE = 1'b0;

        // Flush during LU_M: still a bubble, FSM returns to RUN
        setd(1, 5'd1, 5'd9, 5'd0, 0, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "lw9");
        setd(1, 5'd9, 5'd2, 5'd4, 1, 0, 2'd0, 2'd0);
        step(1, BUBBLE, "fl_b1");
        flushE = 1'b1;
        step(1, BUBBLE, "fl_b2");
        flushE = 1'b0;
        forwardingA = 2'd1;
        step(0, ld(32'h33, 32'h44), "fl_cons");

        // Back-to-back dependent loads, hazard on rt source
        setd(1, 5'd1, 5'd10, 5'd0, 0, 1, 2'd0, 2'd0);
        step(0, ld(32'h11, 32'h44), "lw10");
        setd(1, 5'd10, 5'd11, 5'd0, 0, 1, 2'd0, 2'd0);
        step(1, BUBBLE, "bb_b1");
        step(1, BUBBLE, "bb_b2");
        forwardingA = 2'd1;
        step(0, ld(32'h33, 32'h44), "lw11");
        setd(1, 5'd3, 5'd11, 5'd12, 1, 0, 2'd0, 2'd0);
`ifdef STALL_CNT_EN
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #0;
        release dut.stall_cnt;
        exp_cnt = 32'hFFFF_FFFF;
`endif
        step(1, BUBBLE, "bb_b3");
        step(1, BUBBLE, "bb_b4");
        forwardingB = 2'd1;
        step(0, ld(32'h11, 32'h33), "bb_cons");

        // Reset again mid-run clears everything
        rst_n = 1'b0;
        step(0, BUBBLE, "reset2");
        rst_n = 1'b1;
        setd(1, 5'd1, 5'd2, 5'd3, 1, 0, 2'd2, 2'd1);
        step(0, ld(32'h22, 32'h33), "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
